// File: rtl/frac_div_pkg.sv
// frac_div_pkg: shared widths, ratio limits and DDSM sign-extension helper for the fractional-N divider path.
package frac_div_pkg;
    localparam int N_W = 8;
    localparam int SDM_W = 4;
    localparam int MIN_DIV = 4;
    localparam int MAX_DIV = 255;
    function automatic logic signed [N_W+1:0] sext_sdm(input logic [SDM_W-1:0] s);
        return {{(N_W+2-SDM_W){s[SDM_W-1]}}, s};
    endfunction
endpackage

// File: rtl/frac_ratio_calc.sv
// frac_ratio_calc: adds the signed DDSM word to the integer divide value and clamps to the legal ratio range.
module frac_ratio_calc #(
    parameter int N_W = frac_div_pkg::N_W,
    parameter int SDM_W = frac_div_pkg::SDM_W,
    parameter int MIN_DIV = frac_div_pkg::MIN_DIV,
    parameter int MAX_DIV = frac_div_pkg::MAX_DIV
) (
    input  logic [N_W-1:0]   n_int,
    input  logic [SDM_W-1:0] sdm_in,
    output logic [N_W-1:0]   r,
    output logic             clamped
);
    localparam logic signed [N_W+1:0] MIN_S = (N_W+2)'(MIN_DIV);
    localparam logic signed [N_W+1:0] MAX_S = (N_W+2)'(MAX_DIV);
    logic signed [N_W+1:0] sum;
    always_comb begin
        // two guard bits make the signed add overflow-free for any n_int/sdm_in pair
        sum = $signed({2'b00, n_int}) + $signed({{(N_W+2-SDM_W){sdm_in[SDM_W-1]}}, sdm_in});
        clamped = (sum < MIN_S) || (sum > MAX_S);
        r = (sum < MIN_S) ? N_W'(MIN_DIV) : (sum > MAX_S) ? N_W'(MAX_DIV) : sum[N_W-1:0];
    end
endmodule

// File: rtl/frac_n_mmd_counter.sv
// frac_n_mmd_counter: multi-modulus down-counter dividing clk by n_int + sdm_in (clamped),
// emitting a one-cycle terminal-count strobe that clocks the DDSM once per divided period.
module frac_n_mmd_counter #(
    parameter int N_W = frac_div_pkg::N_W,
    parameter int SDM_W = frac_div_pkg::SDM_W,
    parameter int MIN_DIV = frac_div_pkg::MIN_DIV,
    parameter int MAX_DIV = frac_div_pkg::MAX_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_W-1:0]   n_int,
    input  logic [SDM_W-1:0] sdm_in,
    output logic             div_tick,
    output logic             div_out,
    output logic [N_W-1:0]   ratio,
    output logic             clamp_err
);
    logic [N_W-1:0] cnt_q, cnt_d, half_q, half_d, ratio_q, ratio_d, r;
    logic clamp_q, clamp_d, clamped;
    frac_ratio_calc #(.N_W(N_W), .SDM_W(SDM_W), .MIN_DIV(MIN_DIV), .MAX_DIV(MAX_DIV)) u_calc (
        .n_int(n_int),
        .sdm_in(sdm_in),
        .r(r),
        .clamped(clamped)
    );
    assign div_tick = en & (cnt_q == '0) & ~rst;
    assign div_out = cnt_q >= half_q;
    assign ratio = ratio_q;
    assign clamp_err = clamp_q;
    always_comb begin
        cnt_d = cnt_q;
        half_d = half_q;
        ratio_d = ratio_q;
        clamp_d = clamp_q;
        if (en) begin
            if (cnt_q == '0) begin
                cnt_d = r - 1'b1;
                half_d = r >> 1;
                ratio_d = r;
                clamp_d = clamp_q | clamped;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end
    // half_q resets to 1 so div_out is low straight out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            half_q <= N_W'(1);
            ratio_q <= '0;
            clamp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            half_q <= half_d;
            ratio_q <= ratio_d;
            clamp_q <= clamp_d;
        end
    end
endmodule

// File: tb/tb_frac_n_mmd_counter.sv
// tb_frac_n_mmd_counter: period/phase reference model checked every cycle, directed
// scenarios with literal expectations, and a closed loop with a MASH 1-1-1 modulator.
module tb_frac_n_mmd_counter;
    logic clk = 0, rst = 1, en = 1, loop_mode = 0, chk_on = 0;
    logic [7:0] n_int = 8'd10;
    logic [3:0] sdm_dir = 4'd0;
    logic signed [3:0] ddsm_y = 4'sd0;
    logic [3:0] sdm_in;
    logic div_tick, div_out, clamp_err;
    logic [7:0] ratio;
    int compared = 0, mismatched = 0;
    int m_r = 0, m_k = 0, m_clamp = 0;
    int cyc_n = 0, last_tick = 0, last_period = 0, last_hi = 0, hi_acc = 0;
    int e1, e2, e3, c1, c2, c3, c2d, c3d, c3dd, y;
    int t0, pmin, pmax, tot;

    assign sdm_in = loop_mode ? ddsm_y : sdm_dir;
    always #5 clk = ~clk;

    frac_n_mmd_counter dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .n_int(n_int),
        .sdm_in(sdm_in),
        .div_tick(div_tick),
        .div_out(div_out),
        .ratio(ratio),
        .clamp_err(clamp_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int max);
        bit got = 0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            #1;
            got = div_tick;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL wait_tick: got no div_tick expected one within %0d cycles", max);
        end
        @(posedge clk);
        #1;
    endtask

    // Model: m_k counts cycles elapsed in the current period of m_r cycles.
    always @(posedge clk) begin
        int s, nr;
        if (rst) begin
            m_r = 0;
            m_k = 0;
            m_clamp = 0;
        end else if (en) begin
            if (m_k == m_r) begin
                s = int'(n_int) + int'($signed(sdm_in));
                nr = (s < 4) ? 4 : (s > 255) ? 255 : s;
                if (nr != s) m_clamp = 1;
                m_r = nr;
                m_k = 1;
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tick", int'(div_tick), int'(en && !rst && m_k == m_r));
            chk("div_out", int'(div_out), int'(m_k >= 1 && m_k <= (m_r + 1) / 2));
            chk("ratio", int'(ratio), m_r);
            chk("clamp_err", int'(clamp_err), m_clamp);
            if (rst) begin
                hi_acc = 0;
            end else if (en) begin
                cyc_n++;
                if (div_tick) begin
                    last_period = cyc_n - last_tick;
                    last_tick = cyc_n;
                    last_hi = hi_acc;
                    hi_acc = 0;
                end else if (div_out) begin
                    hi_acc++;
                end
            end
        end
    end

    // MASH 1-1-1 with a = 0x8000, advanced only by div_tick
    always @(posedge clk) begin
        if (rst) begin
            e1 = 0; e2 = 0; e3 = 0; c2d = 0; c3d = 0; c3dd = 0;
            ddsm_y <= 4'sd0;
        end else if (loop_mode && div_tick) begin
            e1 += 32768; c1 = e1 >> 16; e1 &= 65535;
            e2 += e1; c2 = e2 >> 16; e2 &= 65535;
            e3 += e2; c3 = e3 >> 16; e3 &= 65535;
            y = c1 + c2 - c2d + c3 - 2 * c3d + c3dd;
            c2d = c2; c3dd = c3d; c3d = c3;
            ddsm_y <= 4'(y);
        end
    end

    initial begin
        cyc(2);
        chk_on = 1;
        chk("rst_ratio", int'(ratio), 0);
        chk("rst_div_out", int'(div_out), 0);
        chk("rst_clamp", int'(clamp_err), 0);
        chk("rst_tick", int'(div_tick), 0);
        rst = 0;
        #1;
        chk("start_tick", int'(div_tick), 1);
        repeat (3) wait_tick(20);
        chk("n10_period", last_period, 10);
        chk("n10_high", last_hi, 5);
        chk("n10_ratio", int'(ratio), 10);
        chk("n10_clamp", int'(clamp_err), 0);

        sdm_dir = 4'hF;
        cyc(3);
        chk("ratio_hold", int'(ratio), 10);
        repeat (2) wait_tick(20);
        chk("m1_period", last_period, 9);
        chk("m1_high", last_hi, 5);
        chk("m1_ratio", int'(ratio), 9);
        sdm_dir = 4'd3;
        repeat (2) wait_tick(20);
        chk("p3_period", last_period, 13);
        chk("p3_high", last_hi, 7);
        chk("p3_ratio", int'(ratio), 13);

        sdm_dir = 4'd0;
        wait_tick(20);
        cyc(6);
        en = 0;
        cyc(7);
        chk("freeze_ratio", int'(ratio), 10);
        chk("freeze_div_out", int'(div_out), 0);
        chk("freeze_tick", int'(div_tick), 0);
        en = 1;
        cyc(2);
        chk("resume_early_tick", int'(div_tick), 0);
        cyc(1);
        chk("resume_tick", int'(div_tick), 1);
        wait_tick(5);
        chk("freeze_period", last_period, 10);

        cyc(4);
        rst = 1;
        cyc(1);
        chk("midrst_ratio", int'(ratio), 0);
        chk("midrst_div_out", int'(div_out), 0);
        chk("midrst_tick", int'(div_tick), 0);
        rst = 0;
        #1;
        chk("midrst_release_tick", int'(div_tick), 1);

        n_int = 8'd8;
        sdm_dir = 4'h8;
        wait_tick(20);
        chk("clamp_lo_ratio", int'(ratio), 4);
        chk("clamp_lo_flag", int'(clamp_err), 1);
        repeat (2) wait_tick(10);
        chk("clamp_lo_period", last_period, 4);
        chk("clamp_lo_high", last_hi, 2);
        n_int = 8'd255;
        sdm_dir = 4'd7;
        wait_tick(10);
        wait_tick(300);
        chk("clamp_hi_period", last_period, 255);
        chk("clamp_hi_high", last_hi, 128);
        chk("clamp_hi_ratio", int'(ratio), 255);
        chk("clamp_sticky", int'(clamp_err), 1);
        rst = 1;
        cyc(1);
        chk("rst_clears_clamp", int'(clamp_err), 0);

        loop_mode = 1;
        n_int = 8'd20;
        cyc(1);
        rst = 0;
        wait_tick(30);
        t0 = last_tick;
        pmin = 1000;
        pmax = 0;
        for (int i = 0; i < 1024; i++) begin
            wait_tick(40);
            if (last_period < pmin) pmin = last_period;
            if (last_period > pmax) pmax = last_period;
        end
        tot = last_tick - t0;
        chk_rng("loop_total", tot, 20984, 21000);
        chk_rng("loop_pmin", pmin, 17, 28);
        chk_rng("loop_pmax", pmax, 17, 28);
        chk("loop_clamp", int'(clamp_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
